memory_router: RTL

- Parametrised N-slave memory bus router between the cpu memory port and its peripherals (bram, uart, clint, future slaves).
- Replaces hard-coded address decode and ready priority-mux with a table-driven decoder.
- Tracks one outstanding transaction and accepts ready/rdata only from the addressed slave.
- Returns an error response for unmapped addresses and, optionally, for slaves that never answer.

---
 rtl/memory_router.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/memory_router.sv
// memory_router: table-driven N-slave memory bus router.
//
// This block sits between the CPU memory port and its peripherals. It picks
// the target slave from the ADDR_BASE/ADDR_TOP window tables and keeps one
// transaction outstanding at a time. Only the addressed slave's ready and
// rdata are accepted. An unmapped address gets an error response.
//
// Parameters:
//   SLAVES    number of slave ports (1..16)
//   ADDR_BASE packed SLAVES*32 vector; slice k is the inclusive base of slave k
//   ADDR_TOP  packed SLAVES*32 vector; slice k is the exclusive top of slave k
//   TIMEOUT   number of WAIT cycles before a timeout error (optional feature)
//
// Optional feature, enabled by defining MEMORY_ROUTER_TIMEOUT_EN:
//   A 32-bit watchdog runs while in WAIT. If the selected slave has not
//   answered when the watchdog reaches TIMEOUT, the CPU gets an error
//   response. Without the macro, no watchdog is built and WAIT lasts until
//   the slave answers.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   memory_valid/instr/addr/wdata/wstrb   request from the CPU
//   memory_rdata/ready/error response to the CPU (error qualifies ready)
//   slave_valid              one-hot request strobe, one cycle per request
//   slave_instr/addr/wdata/wstrb  forwarded request (addr is window offset)
//   slave_rdata, slave_ready per-slave response inputs
//   busy                     a transaction is outstanding
module memory_router #(
  parameter int                   SLAVES    = 3,
  parameter logic [SLAVES*32-1:0] ADDR_BASE = {SLAVES{32'h0}},
  parameter logic [SLAVES*32-1:0] ADDR_TOP  = {SLAVES{32'h0}},
  parameter int                   TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 memory_valid,
  input  logic                 memory_instr,
  input  logic [31:0]          memory_addr,
  input  logic [31:0]          memory_wdata,
  input  logic [3:0]           memory_wstrb,
  output logic [31:0]          memory_rdata,
  output logic                 memory_ready,
  output logic                 memory_error,
  output logic [SLAVES-1:0]    slave_valid,
  output logic                 slave_instr,
  output logic [31:0]          slave_addr,
  output logic [31:0]          slave_wdata,
  output logic [3:0]           slave_wstrb,
  input  logic [SLAVES*32-1:0] slave_rdata,
  input  logic [SLAVES-1:0]    slave_ready,
  output logic                 busy
);

  localparam int SEL_W = (SLAVES > 1) ? $clog2(SLAVES) : 1;

  // Reject configurations outside the supported range at elaboration time.
  if (SLAVES < 1 || SLAVES > 16 || TIMEOUT < 1) begin : g_param_check
    $error("memory_router: SLAVES must be 1..16 and TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  state_t             state;
  logic [SEL_W-1:0]   sel;
  logic               lat_instr;
  logic [31:0]        lat_addr;
  logic [31:0]        lat_wdata;
  logic [3:0]         lat_wstrb;

  logic               hit_any;
  logic [SEL_W-1:0]   hit_idx;
  logic [31:0]        hit_offset;
  logic [31:0]        hit_rdata;
  logic               hit_ready;
  logic [31:0]        sel_rdata;
  logic               sel_ready;
  logic               timed_out;

`ifdef MEMORY_ROUTER_TIMEOUT_EN
  logic [31:0]        wait_cnt;
  assign timed_out = (state == WAIT) && !sel_ready && (wait_cnt == 32'(TIMEOUT));
`else
  assign timed_out = 1'b0;
`endif

  // Address decode and response muxing. The scan runs from the highest
  // index down so that the lowest-index window wins when windows overlap.
  // A window with base >= top can never satisfy base <= addr < top.
  // The response mux for the latched selection shares the same loop.
  always_comb begin
    hit_any    = 1'b0;
    hit_idx    = '0;
    hit_offset = memory_addr;
    hit_rdata  = 32'h0;
    hit_ready  = 1'b0;
    sel_rdata  = 32'h0;
    sel_ready  = 1'b0;
    for (int k = SLAVES - 1; k >= 0; k--) begin
      if (memory_addr >= ADDR_BASE[k*32 +: 32] && memory_addr < ADDR_TOP[k*32 +: 32]) begin
        hit_any    = 1'b1;
        hit_idx    = SEL_W'(k);
        hit_offset = memory_addr - ADDR_BASE[k*32 +: 32];
        hit_rdata  = slave_rdata[k*32 +: 32];
        hit_ready  = slave_ready[k];
      end
      if (SEL_W'(k) == sel) begin
        sel_rdata = slave_rdata[k*32 +: 32];
        sel_ready = slave_ready[k];
      end
    end
  end

  // Transaction FSM. A hit latches the request and the slave index. If the
  // slave answers in the same cycle, the response is given combinationally
  // and the FSM stays in IDLE. Otherwise the FSM waits in WAIT. A miss takes
  // the one-cycle ERR path. Reset drops any outstanding transaction with no
  // response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sel       <= '0;
      lat_instr <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_wstrb <= 4'h0;
`ifdef MEMORY_ROUTER_TIMEOUT_EN
      wait_cnt  <= 32'h0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (memory_valid) begin
            if (hit_any) begin
              sel       <= hit_idx;
              lat_instr <= memory_instr;
              lat_addr  <= hit_offset;
              lat_wdata <= memory_wdata;
              lat_wstrb <= memory_wstrb;
              if (!hit_ready) begin
                state <= WAIT;
`ifdef MEMORY_ROUTER_TIMEOUT_EN
                wait_cnt <= 32'h0;
`endif
              end
            end else begin
              state <= ERR;
            end
          end
        end
        WAIT: begin
          if (sel_ready) begin
            state <= IDLE;
          end else if (timed_out) begin
            state <= IDLE;
          end else begin
`ifdef MEMORY_ROUTER_TIMEOUT_EN
            wait_cnt <= wait_cnt + 32'd1;
`endif
          end
        end
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output steering. Every output is gated by rst so that asserting reset
  // forces all outputs to zero at once, including the paths that are
  // combinational from the CPU bus.
  always_comb begin
    memory_rdata = 32'h0;
    memory_ready = 1'b0;
    memory_error = 1'b0;
    slave_valid  = '0;
    slave_instr  = 1'b0;
    slave_addr   = 32'h0;
    slave_wdata  = 32'h0;
    slave_wstrb  = 4'h0;
    busy         = 1'b0;
    if (rst) begin
      busy = (state != IDLE);
      case (state)
        IDLE: begin
          slave_instr = memory_instr;
          slave_addr  = hit_offset;
          slave_wdata = memory_wdata;
          slave_wstrb = memory_wstrb;
          if (memory_valid && hit_any) begin
            for (int k = 0; k < SLAVES; k++) begin
              if (SEL_W'(k) == hit_idx) slave_valid[k] = 1'b1;
            end
            if (hit_ready) begin
              memory_ready = 1'b1;
              memory_rdata = hit_rdata;
            end
          end
        end
        WAIT: begin
          slave_instr = lat_instr;
          slave_addr  = lat_addr;
          slave_wdata = lat_wdata;
          slave_wstrb = lat_wstrb;
          if (sel_ready) begin
            memory_ready = 1'b1;
            memory_rdata = sel_rdata;
          end else if (timed_out) begin
            memory_ready = 1'b1;
            memory_error = 1'b1;
          end
        end
        ERR: begin
          memory_ready = 1'b1;
          memory_error = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
